// File: rtl/sfifo_axis_reader_if.sv
// Command, FIFO read-port and AXI-stream signals of the FIFO-to-stream reader.
// master is the reader's view; slave is the view of the surrounding logic.
interface sfifo_axis_reader_if #(
  parameter int BW    = 32,
  parameter int LGLEN = 8
);
  logic             i_start;
  logic [LGLEN-1:0] i_len;
  logic             i_abort;
  logic             o_busy;
  logic             o_done;
  logic             o_aborted;
  logic             o_fifo_rd;
  logic             i_fifo_empty;
  logic [BW-1:0]    i_fifo_data;
  logic             M_AXIS_TVALID;
  logic             M_AXIS_TREADY;
  logic [BW-1:0]    M_AXIS_TDATA;
  logic             M_AXIS_TLAST;

  modport master (
    input  i_start, i_len, i_abort, i_fifo_empty, i_fifo_data, M_AXIS_TREADY,
    output o_busy, o_done, o_aborted, o_fifo_rd,
           M_AXIS_TVALID, M_AXIS_TDATA, M_AXIS_TLAST
  );

  modport slave (
    output i_start, i_len, i_abort, i_fifo_empty, i_fifo_data, M_AXIS_TREADY,
    input  o_busy, o_done, o_aborted, o_fifo_rd,
           M_AXIS_TVALID, M_AXIS_TDATA, M_AXIS_TLAST
  );
endinterface

// File: rtl/sfifo_axis_reader.sv
// Pops words from an async-read FIFO and emits one AXI-stream packet per start
// command, with TLAST on the final word. One word per clock when unstalled.
module sfifo_axis_reader #(
  parameter int BW    = 32,
  parameter int LGLEN = 8
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  sfifo_axis_reader_if.master   bus
);

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DRAIN} state_t;

  state_t           state;
  logic [LGLEN-1:0] remaining;
  logic [BW-1:0]    tdata_p1;
  logic             tvalid_p1;
  logic             tlast_p1;
  logic             busy;
  logic             done;
  logic             aborted;
  logic             adv;
  logic             pop;
  logic             accept;

  assign adv    = !tvalid_p1 || bus.M_AXIS_TREADY;
  assign pop    = (state == STREAM) && !bus.i_fifo_empty && adv && !bus.i_abort;
  assign accept = tvalid_p1 && bus.M_AXIS_TREADY;

  assign bus.o_fifo_rd     = pop;
  assign bus.M_AXIS_TVALID = tvalid_p1;
  assign bus.M_AXIS_TDATA  = tdata_p1;
  assign bus.M_AXIS_TLAST  = tlast_p1;
  assign bus.o_busy        = busy;
  assign bus.o_done        = done;
  assign bus.o_aborted     = aborted;

  // Pop stage: FIFO word captured into the output register
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state     <= IDLE;
      remaining <= '0;
      tdata_p1  <= '0;
      tvalid_p1 <= 1'b0;
      tlast_p1  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;

      if (pop) begin
        tdata_p1  <= bus.i_fifo_data;
        tvalid_p1 <= 1'b1;
        tlast_p1  <= (remaining == LGLEN'(1));
        remaining <= remaining - LGLEN'(1);
      end else if (accept) begin
        tvalid_p1 <= 1'b0;
        tlast_p1  <= 1'b0;
      end

      case (state)
        IDLE: begin
          // The cycle carrying the done pulse still rejects a new start
          if (bus.i_start && (bus.i_len != '0) && !done) begin
            state     <= STREAM;
            remaining <= bus.i_len;
            busy      <= 1'b1;
          end
        end
        STREAM: begin
          if (bus.i_abort) begin
            if (adv) begin
              state   <= IDLE;
              busy    <= 1'b0;
              done    <= 1'b1;
              aborted <= 1'b1;
            end else begin
              state <= DRAIN;
            end
          end else if (pop && (remaining == LGLEN'(1))) begin
            state <= FLUSH;
          end
        end
        FLUSH: begin
          if (accept) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DRAIN: begin
          // Abort seen while a beat was stalled: finish that beat, then stop
          if (accept) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b1;
            aborted <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sfifo_axis_reader.sv
// Bench for sfifo_axis_reader: FIFO model, beat scoreboard, table of packet
// vectors and hand-written abort / start-while-busy / reset sequences.
module tb_sfifo_axis_reader;
  localparam int BW    = 32;
  localparam int LGLEN = 8;
  localparam int LIM   = 2000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sfifo_axis_reader_if #(.BW(BW), .LGLEN(LGLEN)) bus ();

  sfifo_axis_reader #(.BW(BW), .LGLEN(LGLEN)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  // FIFO model: async read of the head word, pop on the clock edge
  logic [BW-1:0] fmem [0:255];
  int wp = 0;
  int rp = 0;
  assign bus.i_fifo_empty = (wp == rp);
  assign bus.i_fifo_data  = fmem[rp % 256];
  always @(posedge clk) if (rst_n && bus.o_fifo_rd) rp <= rp + 1;

  int checks = 0;
  int passed = 0;
  int pop_cnt, beat_cnt, done_cnt, ab_cnt;
  logic [BW:0] exp_q [$];
  logic [7:0] pat;
  logic manual;
  int cyc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic push_word(input logic [BW-1:0] w);
    fmem[wp % 256] = w;
    wp++;
  endtask

  task automatic tick();
    @(posedge clk); #1;
    cyc++;
    if (!manual) bus.M_AXIS_TREADY = pat[cyc[2:0]];
  endtask

  task automatic clear_counts();
    pop_cnt = 0; beat_cnt = 0; done_cnt = 0; ab_cnt = 0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!bus.o_done && n < LIM) begin tick(); n++; end
    if (n >= LIM) chk("timeout", 64'(n), 64'(0));
  endtask

  // Monitor: scoreboard on handshakes, AXI hold rule, pop legality
  logic prev_stall = 1'b0;
  logic [BW-1:0] prev_data;
  logic prev_last;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_data", 64'(bus.M_AXIS_TDATA), 64'(prev_data));
        chk("hold_last", 64'(bus.M_AXIS_TLAST), 64'(prev_last));
      end
      if (bus.o_fifo_rd) begin
        pop_cnt++;
        chk("rd_when_empty", 64'(bus.i_fifo_empty), 64'(0));
      end
      if (bus.M_AXIS_TVALID && !bus.M_AXIS_TREADY)
        chk("rd_in_stall", 64'(bus.o_fifo_rd), 64'(0));
      if (bus.M_AXIS_TVALID && bus.M_AXIS_TREADY) begin
        beat_cnt++;
        if (exp_q.size() == 0) chk("beat_extra", 64'(bus.M_AXIS_TDATA), 64'(exp_q.size()));
        else chk("beat", 64'({bus.M_AXIS_TLAST, bus.M_AXIS_TDATA}), 64'(exp_q.pop_front()));
      end
      if (bus.o_done) done_cnt++;
      if (bus.o_aborted) ab_cnt++;
      prev_stall = bus.M_AXIS_TVALID && !bus.M_AXIS_TREADY;
      prev_data  = bus.M_AXIS_TDATA;
      prev_last  = bus.M_AXIS_TLAST;
    end
  end

  task automatic run_packet(input int len, input int pre, input logic [7:0] p, input int exp_cyc);
    int n;
    logic [BW-1:0] w;
    manual = 1'b0; pat = p; cyc = 0;
    bus.M_AXIS_TREADY = pat[0];
    clear_counts();
    for (int i = 0; i < pre; i++) begin
      w = $urandom;
      push_word(w);
      if (i < len) exp_q.push_back({(i == len - 1), w});
    end
    bus.i_start = 1'b1; bus.i_len = LGLEN'(len);
    tick();
    bus.i_start = 1'b0;
    n = 1;
    while (!bus.o_done && n < LIM) begin tick(); n++; end
    if (exp_cyc != 0) chk("latency", 64'(n), 64'(exp_cyc));
    tick(); tick();
    chk("pops", 64'(pop_cnt), 64'(len));
    chk("beats", 64'(beat_cnt), 64'(len));
    chk("done_cnt", 64'(done_cnt), 64'(1));
    chk("abort_cnt", 64'(ab_cnt), 64'(0));
    chk("busy_end", 64'(bus.o_busy), 64'(0));
    chk("sb_empty", 64'(exp_q.size()), 64'(0));
    chk("fifo_left", 64'(wp - rp), 64'(pre - len));
    wp = rp;
  endtask

  typedef struct {
    int         len;
    int         pre;
    logic [7:0] pat;
    int         cyc;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int n;
    logic [BW-1:0] w;
    vecs[0] = '{len: 4,   pre: 4,   pat: 8'hFF, cyc: 6};
    vecs[1] = '{len: 3,   pre: 3,   pat: 8'h55, cyc: 0};
    vecs[2] = '{len: 1,   pre: 1,   pat: 8'hFF, cyc: 3};
    vecs[3] = '{len: 255, pre: 255, pat: 8'hDB, cyc: 0};
    vecs[4] = '{len: 5,   pre: 7,   pat: 8'hFF, cyc: 7};
    vecs[5] = '{len: 6,   pre: 6,   pat: 8'h0F, cyc: 0};

    rst_n = 1'b0; manual = 1'b1; pat = 8'hFF; cyc = 0;
    bus.i_start = 1'b0; bus.i_len = '0; bus.i_abort = 1'b0; bus.M_AXIS_TREADY = 1'b1;
    clear_counts();
    #12;
    chk("rst_tvalid", 64'(bus.M_AXIS_TVALID), 64'(0));
    chk("rst_tlast", 64'(bus.M_AXIS_TLAST), 64'(0));
    chk("rst_tdata", 64'(bus.M_AXIS_TDATA), 64'(0));
    chk("rst_busy", 64'(bus.o_busy), 64'(0));
    chk("rst_done", 64'({bus.o_done, bus.o_aborted}), 64'(0));
    chk("rst_rd", 64'(bus.o_fifo_rd), 64'(0));
    tick(); rst_n = 1'b1; tick();

    foreach (vecs[i]) run_packet(vecs[i].len, vecs[i].pre, vecs[i].pat, vecs[i].cyc);

    // FIFO empty at start, one word every 3 clocks
    manual = 1'b1; bus.M_AXIS_TREADY = 1'b1; clear_counts();
    bus.i_start = 1'b1; bus.i_len = 8'd2;
    tick(); bus.i_start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      repeat (3) tick();
      w = $urandom; push_word(w); exp_q.push_back({(k == 1), w});
    end
    wait_done(n);
    tick();
    chk("trickle_pops", 64'(pop_cnt), 64'(2));
    chk("trickle_beats", 64'(beat_cnt), 64'(2));
    chk("trickle_done", 64'(done_cnt), 64'(1));

    // Abort with a 4th beat stalled in the output register
    clear_counts();
    for (int i = 0; i < 8; i++) begin
      w = $urandom; push_word(w);
      if (i < 4) exp_q.push_back({1'b0, w});
    end
    bus.i_start = 1'b1; bus.i_len = 8'd8;
    tick(); bus.i_start = 1'b0;
    n = 0;
    while (beat_cnt < 3 && n < 50) begin tick(); n++; end
    bus.M_AXIS_TREADY = 1'b0; bus.i_abort = 1'b1;
    tick(); bus.i_abort = 1'b0;
    repeat (3) tick();
    chk("abort_held_valid", 64'(bus.M_AXIS_TVALID), 64'(1));
    chk("abort_held_busy", 64'(bus.o_busy), 64'(1));
    chk("abort_no_done", 64'(done_cnt), 64'(0));
    bus.M_AXIS_TREADY = 1'b1;
    wait_done(n);
    chk("abort_pulse", 64'({bus.o_done, bus.o_aborted}), 64'(3));
    tick();
    chk("abort_pops", 64'(pop_cnt), 64'(4));
    chk("abort_beats", 64'(beat_cnt), 64'(4));
    chk("abort_counts", 64'({done_cnt[7:0], ab_cnt[7:0]}), 64'(16'h0101));
    chk("abort_fifo_left", 64'(wp - rp), 64'(4));
    wp = rp;

    // Abort with nothing pending
    clear_counts();
    bus.i_start = 1'b1; bus.i_len = 8'd4;
    tick(); bus.i_start = 1'b0;
    tick(); bus.i_abort = 1'b1;
    tick(); bus.i_abort = 1'b0;
    chk("idle_abort_pulse", 64'({bus.o_done, bus.o_aborted, bus.o_busy}), 64'(3'b110));
    tick();
    chk("idle_abort_once", 64'(bus.o_done), 64'(0));

    // Zero-length start, start while busy, start during the done cycle
    clear_counts();
    for (int i = 0; i < 3; i++) begin
      w = $urandom; push_word(w); exp_q.push_back({(i == 2), w});
    end
    bus.i_start = 1'b1; bus.i_len = 8'd0;
    tick(); bus.i_start = 1'b0;
    tick(); tick();
    chk("len0_busy", 64'(bus.o_busy), 64'(0));
    chk("len0_pops", 64'(pop_cnt), 64'(0));
    bus.M_AXIS_TREADY = 1'b0;
    bus.i_start = 1'b1; bus.i_len = 8'd3;
    tick(); bus.i_start = 1'b0;
    tick(); tick();
    bus.i_start = 1'b1; bus.i_len = 8'd5;
    tick(); bus.i_start = 1'b0;
    chk("busy_restart", 64'(bus.o_busy), 64'(1));
    bus.M_AXIS_TREADY = 1'b1;
    wait_done(n);
    w = $urandom; push_word(w);
    w = $urandom; push_word(w);
    bus.i_start = 1'b1; bus.i_len = 8'd2;
    tick(); bus.i_start = 1'b0;
    tick(); tick();
    chk("busy_pops", 64'(pop_cnt), 64'(3));
    chk("donecyc_busy", 64'(bus.o_busy), 64'(0));
    chk("donecyc_fifo_left", 64'(wp - rp), 64'(2));
    wp = rp;

    // Reset in the middle of a stalled packet
    clear_counts();
    for (int i = 0; i < 4; i++) begin w = $urandom; push_word(w); end
    bus.M_AXIS_TREADY = 1'b0;
    bus.i_start = 1'b1; bus.i_len = 8'd4;
    tick(); bus.i_start = 1'b0;
    tick(); tick();
    chk("pre_rst_valid", 64'(bus.M_AXIS_TVALID), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(bus.M_AXIS_TVALID), 64'(0));
    chk("mid_rst_rd", 64'(bus.o_fifo_rd), 64'(0));
    chk("mid_rst_busy", 64'(bus.o_busy), 64'(0));
    exp_q.delete();
    tick(); tick();
    rst_n = 1'b1;
    wp = rp;
    tick();
    run_packet(2, 2, 8'hFF, 4);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
